jk_bank_arbiter: RTL
====================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal values are 2 to 8.
REQ-002 Parameter NBITS, default 8, number of JK bits in the bank; legal values are 2 to 256 and a power of 2.
REQ-003 Parameter IDXW, default 3, bit-index width, equal to log2(NBITS).
REQ-004 The clock SHALL be clk, input, 1 bit; the block uses this single clock and all state updates on its rising edge.
REQ-005 The reset SHALL be reset, input, 1 bit; it is asynchronous and active-high.
REQ-006 req SHALL be an input of NREQ bits: requester i asks to issue a command.
REQ-007 j SHALL be an input of NREQ bits, giving the J operand per requester.
REQ-008 k SHALL be an input of NREQ bits, giving the K operand per requester.
REQ-009 idx SHALL be an input of NREQ*IDXW bits; slice i is requester i's target bit.
REQ-010 clr SHALL be an input of 1 bit: synchronous clear of the whole bank.
REQ-011 gnt SHALL be an output of NREQ bits: a combinational one-hot grant.
REQ-012 q SHALL be an output of NBITS bits, the registered bank state.
REQ-013 busy SHALL be an output of 1 bit, high while the apply stage holds a command.

Function
REQ-014 gnt SHALL be one-hot or zero and depend only on req, clr and the round-robin pointer ptr.
REQ-015 Arbitration SHALL search from requester ptr upward, wrapping modulo NREQ; the first requester with req high wins.
REQ-016 A command is accepted at a rising edge where req[i] and gnt[i] are both high; its j, k and idx slice are captured into the apply stage and busy is set.
REQ-017 On accept, ptr SHALL become (winner+1) mod NREQ; with no accept, ptr SHALL hold.
REQ-018 One edge after accept, q[idx] SHALL update per the JK truth table: 00 holds, 01 clears to 0, 10 sets to 1, 11 toggles; all other bits hold.
REQ-019 busy SHALL clear on the apply edge unless a new command is accepted on the same edge.
REQ-020 Sustained throughput SHALL be one command per cycle; accept-to-q latency is 2 edges.
REQ-021 Back-to-back commands to the same idx SHALL apply in order, each command seeing the result of the previous one.
REQ-022 A requester holding req high after its grant is treated as issuing a new command; the rotating ptr prevents starvation.
REQ-023 When clr is high: gnt is forced to 0; at the edge all q bits go to 0; the pending stage is discarded (busy goes to 0); ptr holds.

Reset
REQ-024 Asserting reset SHALL immediately force q=0, busy=0, ptr=0 and the stage contents to 0; gnt is then 0 unless req is asserted.
REQ-025 Reset mid-operation SHALL drop any pending command without applying it.
REQ-026 After reset deasserts, the first accept is possible on the first rising edge.

Configuration
REQ-027 Macro JK_ARB_GNT_CNT_EN SHALL control optional grant counters.
REQ-028 When JK_ARB_GNT_CNT_EN is defined, output gnt_cnt (NREQ*8 bits) SHALL exist; slice i increments on each accept by requester i and saturates at 255.
REQ-029 The gnt_cnt counters SHALL be cleared by reset and SHALL NOT be affected by clr.
REQ-030 When JK_ARB_GNT_CNT_EN is undefined, port gnt_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then req=0001 with j=1, k=0, idx0=5 for one cycle: gnt=0001 and busy=1 after edge 1; q=0x20 after edge 2.
REQ-032 req=1111 held for 8 cycles with all j=k=1 on distinct idx: grants rotate 0,1,2,3,0,1,2,3 and each target bit toggles twice, ending at 0.
REQ-033 Requester 2 issues idx=3 commands 10, 11, 11, 01 on consecutive cycles: q[3] goes 1, 0, 1, 0 on successive edges.
REQ-034 With q=0xFF, assert clr while req=0010 is high: gnt=0, q=0x00 next edge, and no update follows.
REQ-035 Assert reset asynchronously between accept and apply: q=0 and busy=0 immediately, and the pending command is never applied.
REQ-036 With JK_ARB_GNT_CNT_EN defined, grant requester 0 300 times: gnt_cnt[7:0]=255; without the macro, the bench compiles with no gnt_cnt port.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that feeds a two-stage command pipe
// into a bank of NBITS JK flip-flops. Requesters compete for a one-hot
// grant. The winning command (j, k, idx) is captured into an apply stage and
// written to q one edge later. Throughput is one command per cycle.
//
// Optional feature: define JK_ARB_GNT_CNT_EN to add the gnt_cnt port. It holds
// one 8-bit saturating grant counter per requester.
//
// Handshake: req[i] is the requester's valid and gnt[i] is its ready. A
// command transfers on a rising edge where both are high. gnt is
// combinational from req, clr and the round-robin pointer. A requester may
// drop req at any time. Holding req high after a transfer presents a new
// command.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      j,
  input  logic [NREQ-1:0]      k,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic                 busy
`ifdef JK_ARB_GNT_CNT_EN
  ,
  output logic [NREQ*8-1:0]    gnt_cnt
`endif
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] win;
  logic            accept;
  logic            st_j;
  logic            st_k;
  logic [IDXW-1:0] st_idx;

  // Round-robin search: first requester at or above ptr, then wrap to those below it.
  always_comb begin
    gnt    = '0;
    win    = '0;
    accept = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!clr && !accept && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        win    = PTRW'(i);
        accept = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!clr && !accept && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        win    = PTRW'(i);
        accept = 1'b1;
      end
    end
  end

  // Pointer, apply stage and bank. Applying the old stage and capturing a new
  // command share one edge, so same-bit commands resolve in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      busy   <= 1'b0;
      st_j   <= 1'b0;
      st_k   <= 1'b0;
      st_idx <= '0;
      q      <= '0;
    end else if (clr) begin
      busy   <= 1'b0;
      st_j   <= 1'b0;
      st_k   <= 1'b0;
      st_idx <= '0;
      q      <= '0;
    end else begin
      if (busy) begin
        case ({st_j, st_k})
          2'b01:   q[st_idx] <= 1'b0;
          2'b10:   q[st_idx] <= 1'b1;
          2'b11:   q[st_idx] <= ~q[st_idx];
          default: q[st_idx] <= q[st_idx];
        endcase
      end
      if (accept) begin
        busy   <= 1'b1;
        st_j   <= j[win];
        st_k   <= k[win];
        st_idx <= idx[int'(win)*IDXW +: IDXW];
        ptr    <= (win == PTRW'(NREQ-1)) ? '0 : win + 1'b1;
      end else begin
        busy   <= 1'b0;
      end
    end
  end

`ifdef JK_ARB_GNT_CNT_EN
  // Per-requester grant counters. They saturate at 255. clr leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (gnt_cnt[i*8 +: 8] != 8'hFF)) begin
          gnt_cnt[i*8 +: 8] <= gnt_cnt[i*8 +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule
